// File: rtl/i2c_slave_rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rtc_pkg
// Brief    : Shared types and register-map constants for the PCF8563-style
//            I2C target (FSM state encoding, time register addresses and
//            reset-value helper).
// Revision : 1.0 - initial release
// ============================================================================
package i2c_slave_rtc_pkg;

  // Protocol FSM states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WADDR     = 4'd3,
    ST_WADDR_ACK = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8
  } state_e;

  // Time-keeping registers preset from TIME_INI
  localparam logic [3:0] REG_SEC  = 4'h2;
  localparam logic [3:0] REG_MIN  = 4'h3;
  localparam logic [3:0] REG_HOUR = 4'h4;
  localparam logic [3:0] REG_DAY  = 4'h5;
  localparam logic [3:0] REG_MON  = 4'h7;
  localparam logic [3:0] REG_YEAR = 4'h8;

  localparam int NUM_REGS = 16;

  // Reset contents of register 'a' given packed YY_MM_DD_hh_mm_ss (BCD)
  function automatic logic [7:0] reset_value(input logic [47:0] ini, input logic [3:0] a);
    case (a)
      REG_YEAR: return ini[47:40];
      REG_MON:  return ini[39:32];
      REG_DAY:  return ini[31:24];
      REG_HOUR: return ini[23:16];
      REG_MIN:  return ini[15:8];
      REG_SEC:  return ini[7:0];
      default:  return 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Brief    : Brings the asynchronous SCL/SDA pins into sys_clk, filters
//            glitches shorter than DEB_LEN cycles and emits one-cycle
//            scl_rise / scl_fall / start / stop pulses plus the clean SDA level.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
  parameter int DEB_LEN = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int CW = $clog2(DEB_LEN + 1);

  // Index 0 carries SCL, index 1 carries SDA
  logic [1:0] w_pins;
  logic [1:0] w_filt;
  logic [1:0] prev_q;
  logic [1:0] prev_d;

  assign w_pins = {sda_i, scl_i};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          filt_q;
    logic          filt_d;

    // Shift pin into the synchroniser; accept a new level only after it has
    // differed from the filtered level for DEB_LEN consecutive cycles
    always_comb begin
      sync_d = {sync_q[0], w_pins[g]};
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CW'(DEB_LEN - 1)) begin
          filt_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Synchroniser and filter state; idle bus level is high
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        filt_q <= 1'b1;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign w_filt[g] = filt_q;
  end : g_chan

  assign prev_d = w_filt;

  // Delayed copy of the filtered levels for edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev_q <= 2'b11;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign sda_lvl  = w_filt[1];
  assign scl_rise =  w_filt[0] & ~prev_q[0];
  assign scl_fall = ~w_filt[0] &  prev_q[0];
  assign start    =  w_filt[0] &  prev_q[0] &  prev_q[1] & ~w_filt[1];
  assign stop     =  w_filt[0] &  prev_q[0] & ~prev_q[1] &  w_filt[1];

endmodule
`default_nettype wire

// File: rtl/i2c_slave_rtc.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rtc
// Brief    : I2C target emulating the PCF8563 16 x 8-bit register map.
//            Auto-incrementing register pointer, user read port and a
//            write-notification strobe for every committed bus byte.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_rtc
  import i2c_slave_rtc_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h51,
  parameter logic [47:0] TIME_INI   = 48'h18_05_23_09_30_00,
  parameter int          DEB_LEN    = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_pulse,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic w_sda_lvl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_bus_sync #(
    .DEB_LEN (DEB_LEN)
  ) u_bus_sync (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_lvl  (w_sda_lvl),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  state_e     state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;   // SCL rises seen in the current byte, 0..8
  logic [7:0] sr_q,       sr_d;        // receive shift register
  logic [7:0] tx_q,       tx_d;        // transmit byte, current bit at [7]
  logic [3:0] ptr_q,      ptr_d;
  logic       rw_q,       rw_d;
  logic       sda_oe_q,   sda_oe_d;
  logic       busy_q,     busy_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [3:0] wr_addr_q,  wr_addr_d;
  logic [7:0] wr_data_q,  wr_data_d;
  logic [7:0] rd_data_q,  rd_data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       w_counting;
  logic       w_byte_done;
  logic [3:0] w_next_ptr;

  // Bits are clocked in only in states that carry a data/ack bit from the master
  // or count bits going out; ACK states of our own do not count.
  assign w_counting  = (state_q == ST_ADDR)  || (state_q == ST_WADDR) ||
                       (state_q == ST_WDATA) || (state_q == ST_RDATA) ||
                       (state_q == ST_RACK);
  assign w_byte_done = (bit_cnt_q == 4'd8);
  assign w_next_ptr  = ptr_q + 4'd1;

  // Protocol next-state: STOP/START override everything, then SCL edge handling
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = regs_q[rd_addr];
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (w_stop) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (w_start) begin
      // Pointer survives a repeated START so write-address + re-START read works
      state_d   = ST_ADDR;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      if (w_scl_rise && w_counting && !w_byte_done) begin
        sr_d      = {sr_q[6:0], w_sda_lvl};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if (w_scl_fall) begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_ADDR: begin
            if (w_byte_done) begin
              bit_cnt_d = 4'd0;
              if (sr_q[7:1] == SLAVE_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = sr_q[0];
              end else begin
                state_d  = ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (rw_q) begin
              state_d  = ST_RDATA;
              tx_d     = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = ST_WADDR;
              sda_oe_d = 1'b0;
            end
          end
          ST_WADDR: begin
            if (w_byte_done) begin
              bit_cnt_d = 4'd0;
              ptr_d     = sr_q[3:0];
              state_d   = ST_WADDR_ACK;
              sda_oe_d  = 1'b1;
            end
          end
          ST_WADDR_ACK, ST_WDATA_ACK: begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
          ST_WDATA: begin
            if (w_byte_done) begin
              bit_cnt_d     = 4'd0;
              regs_d[ptr_q] = sr_q;
              wr_pulse_d    = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = sr_q;
              ptr_d         = w_next_ptr;
              state_d       = ST_WDATA_ACK;
              sda_oe_d      = 1'b1;
            end
          end
          ST_RDATA: begin
            if (w_byte_done) begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = ST_RACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
          ST_RACK: begin
            // Acts only once the master's ACK/NACK bit has been sampled
            if (bit_cnt_q == 4'd1) begin
              bit_cnt_d = 4'd0;
              if (!sr_q[0]) begin
                ptr_d    = w_next_ptr;
                tx_d     = regs_q[w_next_ptr];
                sda_oe_d = ~regs_q[w_next_ptr][7];
                state_d  = ST_RDATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_IDLE;
              end
            end
          end
          default: begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
          end
        endcase
      end
    end
  end

  // All protocol, register-file and output state; reset releases SDA immediately
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      sr_q       <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= 4'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= reset_value(TIME_INI, 4'(i));
      end
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rtc.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_rtc
// Brief    : Self-checking bench for i2c_slave_rtc. A bit-level I2C master
//            drives an open-drain bus; a transaction-level register/pointer
//            model supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rtc;

  localparam int          Q     = 10;              // sys_clk cycles per SCL quarter
  localparam logic [6:0]  SADDR = 7'h51;
  localparam logic [47:0] INI   = 48'h18_05_23_09_30_00;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_rtc #(
    .SLAVE_ADDR (SADDR),
    .TIME_INI   (INI),
    .DEB_LEN    (3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents and auto-increment pointer
  logic [7:0]  ref_regs [16];
  logic [3:0]  ref_ptr;
  logic [7:0]  wbuf [8];

  // Bus observers
  logic [11:0] wr_log [$];
  int          oe_cycles   = 0;
  int          busy_cycles = 0;

  always @(negedge sys_clk) begin
    if (wr_pulse) wr_log.push_back({wr_addr, wr_data});
    if (sda_oe)   oe_cycles   = oe_cycles + 1;
    if (busy)     busy_cycles = busy_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
    ref_regs[2] = INI[7:0];     // seconds
    ref_regs[3] = INI[15:8];    // minutes
    ref_regs[4] = INI[23:16];   // hours
    ref_regs[5] = INI[31:24];   // days
    ref_regs[7] = INI[39:32];   // months
    ref_regs[8] = INI[47:40];   // years
    ref_ptr = 4'd0;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    wr_log.delete();
  endtask

  // ---------------- bit-level master ----------------
  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // ---------------- transaction-level scenarios ----------------
  task automatic do_write(input logic [3:0] wa, input int n, input bit send_stop);
    logic        ack_n;
    logic [11:0] got;
    bus_start();
    write_byte({SADDR, 1'b0}, ack_n);
    n_cmp++;
    if (ack_n !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b expected 0", ack_n); end
    write_byte({4'($urandom_range(0, 15)), wa}, ack_n);
    n_cmp++;
    if (ack_n !== 1'b0) begin n_err++; $display("FAIL wr_waddr_ack: got %b expected 0", ack_n); end
    ref_ptr = wa;
    for (int k = 0; k < n; k++) begin
      write_byte(wbuf[k], ack_n);
      n_cmp++;
      if (ack_n !== 1'b0) begin n_err++; $display("FAIL wr_data_ack: byte %0d got %b expected 0", k, ack_n); end
      n_cmp++;
      if (wr_log.size() != 1) begin
        n_err++;
        $display("FAIL wr_pulse_count: byte %0d got %0d pulses expected 1", k, wr_log.size());
        wr_log.delete();
      end else begin
        got = wr_log.pop_front();
        if (got !== {ref_ptr, wbuf[k]}) begin
          n_err++;
          $display("FAIL wr_pulse_payload: got addr %0h data %0h expected addr %0h data %0h",
                   got[11:8], got[7:0], ref_ptr, wbuf[k]);
        end
      end
      ref_regs[ref_ptr] = wbuf[k];
      ref_ptr = ref_ptr + 4'd1;
    end
    if (send_stop) bus_stop();
  endtask

  task automatic do_read(input bit set_wa, input logic [3:0] wa, input int n, input bit send_stop);
    logic       ack_n;
    logic [7:0] d;
    if (set_wa) begin
      bus_start();
      write_byte({SADDR, 1'b0}, ack_n);
      n_cmp++;
      if (ack_n !== 1'b0) begin n_err++; $display("FAIL rd_waddr_dev_ack: got %b expected 0", ack_n); end
      write_byte({4'h0, wa}, ack_n);
      n_cmp++;
      if (ack_n !== 1'b0) begin n_err++; $display("FAIL rd_waddr_ack: got %b expected 0", ack_n); end
      ref_ptr = wa;
    end
    bus_start();
    write_byte({SADDR, 1'b1}, ack_n);
    n_cmp++;
    if (ack_n !== 1'b0) begin n_err++; $display("FAIL rd_dev_ack: got %b expected 0", ack_n); end
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      n_cmp++;
      if (d !== ref_regs[ref_ptr]) begin
        n_err++;
        $display("FAIL rd_byte: reg %0h got %0h expected %0h", ref_ptr, d, ref_regs[ref_ptr]);
      end
      if (k != n - 1) ref_ptr = ref_ptr + 4'd1;
    end
    if (send_stop) bus_stop();
    n_cmp++;
    if (wr_log.size() != 0) begin
      n_err++;
      $display("FAIL rd_no_wr_pulse: got %0d pulses expected 0", wr_log.size());
      wr_log.delete();
    end
  endtask

  task automatic check_port(input logic [3:0] a);
    @(negedge sys_clk);
    rd_addr = a;
    repeat (2) @(negedge sys_clk);
    n_cmp++;
    if (rd_data !== ref_regs[a]) begin
      n_err++;
      $display("FAIL rd_port: addr %0h got %0h expected %0h", a, rd_data, ref_regs[a]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if ({sda_oe, busy, wr_pulse} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got oe/busy/pulse %b expected 000", {sda_oe, busy, wr_pulse});
    end
    n_cmp++;
    if ({wr_addr, wr_data, rd_data} !== 20'h0) begin
      n_err++; $display("FAIL reset_data: got %0h expected 0", {wr_addr, wr_data, rd_data});
    end
    sys_rst = 1'b0;
    model_reset();
    for (int a = 0; a < 16; a++) check_port(4'(a));
  endtask

  task automatic test_single_write();
    wbuf[0] = 8'h45;
    do_write(4'h2, 1, 1'b1);
    check_port(4'h2);
  endtask

  task automatic test_time_read();
    logic [7:0] exp_t [7];
    logic       ack_n;
    logic [7:0] d;
    exp_t = '{8'h00, 8'h30, 8'h09, 8'h23, 8'h00, 8'h05, 8'h18};
    apply_reset();
    bus_start();
    write_byte({SADDR, 1'b0}, ack_n);
    write_byte(8'h02, ack_n);
    bus_start();
    write_byte({SADDR, 1'b1}, ack_n);
    n_cmp++;
    if (ack_n !== 1'b0) begin n_err++; $display("FAIL time_dev_ack: got %b expected 0", ack_n); end
    for (int k = 0; k < 7; k++) begin
      read_byte(k == 6, d);
      n_cmp++;
      if (d !== exp_t[k]) begin
        n_err++; $display("FAIL time_read: byte %0d got %0h expected %0h", k, d, exp_t[k]);
      end
    end
    bus_stop();
  endtask

  task automatic test_wrong_addr();
    logic ack_n;
    int   oe0;
    int   busy0;
    oe0   = oe_cycles;
    busy0 = busy_cycles;
    bus_start();
    write_byte({7'h50, 1'b0}, ack_n);
    send_bit(1'b0);
    n_cmp++;
    if (ack_n !== 1'b1) begin n_err++; $display("FAIL wrong_addr_ack: got %b expected 1", ack_n); end
    bus_stop();
    n_cmp++;
    if (oe_cycles != oe0) begin n_err++; $display("FAIL wrong_addr_oe: got %0d driven cycles expected 0", oe_cycles - oe0); end
    n_cmp++;
    if (busy_cycles != busy0) begin n_err++; $display("FAIL wrong_addr_busy: got %0d busy cycles expected 0", busy_cycles - busy0); end
    n_cmp++;
    if (wr_log.size() != 0) begin
      n_err++; $display("FAIL wrong_addr_pulse: got %0d expected 0", wr_log.size()); wr_log.delete();
    end
  endtask

  task automatic test_wrap_burst();
    for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom);
    do_write(4'hE, 3, 1'b1);
    check_port(4'hE);
    check_port(4'hF);
    check_port(4'h0);
  endtask

  task automatic test_partial_stop();
    logic       ack_n;
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    bus_start();
    write_byte({SADDR, 1'b0}, ack_n);
    write_byte({4'h0, a}, ack_n);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    bus_stop();
    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if (wr_log.size() != 0) begin
      n_err++; $display("FAIL partial_pulse: got %0d expected 0", wr_log.size()); wr_log.delete();
    end
    n_cmp++;
    if ({busy, sda_oe} !== 2'b00) begin n_err++; $display("FAIL partial_idle: got busy/oe %b expected 00", {busy, sda_oe}); end
    check_port(a);
  endtask

  task automatic test_back_to_back();
    logic [3:0] wa;
    int         n;
    for (int it = 0; it < 5; it++) begin
      wa = 4'($urandom_range(0, 15));
      n  = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      do_write(wa, n, 1'($urandom));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 2) == 0) do_read(1'b0, 4'h0, n, 1'($urandom));
      else do_read(1'b1, 4'($urandom_range(0, 15)), n, 1'($urandom));
    end
    bus_stop();
    check_port(4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_mid_read();
    logic ack_n;
    wbuf[0] = 8'h5A;                 // MSB 0, so SDA is pulled as soon as the read starts
    do_write(4'h6, 1, 1'b0);
    bus_start();
    write_byte({SADDR, 1'b0}, ack_n);
    write_byte(8'h06, ack_n);
    bus_start();
    write_byte({SADDR, 1'b1}, ack_n);
    n_cmp++;
    if (sda_oe !== 1'b1) begin n_err++; $display("FAIL midread_driving: got sda_oe %b expected 1", sda_oe); end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (sda_oe !== 1'b0) begin n_err++; $display("FAIL midread_release: got sda_oe %b expected 0", sda_oe); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    wr_log.delete();
    check_port(4'h6);
    check_port(4'h8);
    do_read(1'b1, 4'h2, 3, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_time_read();
    test_wrong_addr();
    test_wrap_burst();
    test_partial_stop();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
